// File: rtl/mnist_pkg.sv
// Shared types and elaboration helpers for the MNIST inference controller.
//   state_e   : frame sequencer states
//   clog2     : ceiling log2 for constant width derivation
//   frame_pix : beats per frame from the frame edge length
//   cls_w     : class index width, never below one bit
package mnist_pkg;

   typedef enum logic [2:0] {WAIT_W, IDLE, FEED, DRAIN, SCAN, RESULT} state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic int frame_pix(input int sz);
      return sz * sz;
   endfunction

   function automatic int cls_w(input int classes);
      return (classes > 1) ? clog2(classes) : 1;
   endfunction

endpackage

// File: rtl/argmax_seq.sv
// Sequential argmax: examines one class score per cycle while scan_i is high.
//   clk_i, rst_ni : clock, async active-low reset
//   scan_i        : compare val_i for class idx_o this cycle
//   val_i         : score of class idx_o (muxed by the parent)
//   idx_o         : class currently being compared
//   last_o        : idx_o is the final class
//   arg_o, max_o  : running winner index and score
module argmax_seq import mnist_pkg::*; #(
   parameter  int CLASSES = 10,
   parameter  int ACC_W   = 16,
   localparam int CLS_W   = cls_w(CLASSES)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    scan_i,
   input  logic signed [ACC_W-1:0] val_i,
   output logic        [CLS_W-1:0] idx_o,
   output logic                    last_o,
   output logic        [CLS_W-1:0] arg_o,
   output logic signed [ACC_W-1:0] max_o
);

   logic        [CLS_W-1:0] idx_q, idx_d, arg_q, arg_d;
   logic signed [ACC_W-1:0] max_q, max_d;

   assign last_o = (idx_q == CLS_W'(CLASSES - 1));
   assign idx_o  = idx_q;
   assign arg_o  = arg_q;
   assign max_o  = max_q;

   always_comb begin
      idx_d = idx_q;
      arg_d = arg_q;
      max_d = max_q;
      if (scan_i) begin
         // class 0 seeds the running max; strict '>' keeps the lowest index on ties
         if (idx_q == '0 || val_i > max_q) begin
            max_d = val_i;
            arg_d = idx_q;
         end
         idx_d = last_o ? '0 : idx_q + CLS_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q <= '0;
         arg_q <= '0;
         max_q <= '0;
      end else begin
         idx_q <= idx_d;
         arg_q <= arg_d;
         max_q <= max_d;
      end
   end

endmodule

// File: rtl/mnist_infer_ctrl.sv
// Frame sequencer and classifier head around the dwconv layer chain.
// Waits for weights, admits one frame of FRAME_PIX beats, accumulates the chain's
// per-class outputs with saturation, runs a sequential argmax and returns the result.
//   clk_i, rst_ni             : clock, async active-low reset
//   wload_done_i              : weight loader finished (only looked at in WAIT_W)
//   s_vld_i/s_rdy_o/s_din_i/s_last_i : pixel input stream
//   chain_vld_o, chain_din_o  : pixel forwarded to layer 1
//   chain_dout_i, chain_vld_in_i, chain_end_i : last-layer outputs, class k at [k*N +: N]
//   res_vld_o/res_rdy_i       : result handshake
//   res_class_o, res_score_o, res_err_o : winner, its score, timeout/frame-length error
module mnist_infer_ctrl import mnist_pkg::*; #(
   parameter  int N          = 8,
   parameter  int IN_CH      = 1,
   parameter  int INPUT_SIZE = 28,
   parameter  int CLASSES    = 10,
   parameter  int OUT_PIXELS = 1,
   parameter  int ACC_W      = 16,
   parameter  int TIMEOUT    = 4096,
   localparam int CLS_W      = cls_w(CLASSES)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   wload_done_i,
   input  logic                   s_vld_i,
   output logic                   s_rdy_o,
   input  logic [IN_CH*N-1:0]     s_din_i,
   input  logic                   s_last_i,
   output logic                   chain_vld_o,
   output logic [IN_CH*N-1:0]     chain_din_o,
   input  logic [CLASSES*N-1:0]   chain_dout_i,
   input  logic                   chain_vld_in_i,
   input  logic                   chain_end_i,
   output logic                   res_vld_o,
   input  logic                   res_rdy_i,
   output logic [CLS_W-1:0]       res_class_o,
   output logic [ACC_W-1:0]       res_score_o,
   output logic                   res_err_o
);

   localparam int FRAME_PIX = frame_pix(INPUT_SIZE);
   localparam int PIX_W     = clog2(FRAME_PIX + 1);
   localparam int TMO_W     = clog2(TIMEOUT + 1);
   // OUT_PIXELS only bounds the accumulator sizing; every chain beat is summed.

   state_e                         state_q, state_d;
   logic [PIX_W-1:0]               pix_q, pix_d;
   logic [TMO_W-1:0]               tmo_q, tmo_d;
   logic                           ferr_q, ferr_d;   // frame-length error
   logic                           endl_q, endl_d;   // chain_end seen while feeding
   logic                           tmof_q, tmof_d;   // drain timed out
   logic [CLASSES-1:0][ACC_W-1:0]  acc_q, acc_d;

   logic                           accept, last_pix, acc_en, acc_clr;
   logic [CLS_W-1:0]               am_idx, am_arg;
   logic                           am_last;
   logic signed [ACC_W-1:0]        am_max;

   assign s_rdy_o     = (state_q == IDLE) || (state_q == FEED);
   assign accept      = s_vld_i & s_rdy_o;
   assign last_pix    = (pix_q == PIX_W'(FRAME_PIX - 1));
   assign chain_vld_o = accept;
   assign chain_din_o = s_din_i;

   assign acc_en  = chain_vld_in_i & ((state_q == FEED) || (state_q == DRAIN));
   assign acc_clr = (state_q == RESULT) & res_rdy_i;

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      tmo_d   = tmo_q;
      ferr_d  = ferr_q;
      endl_d  = endl_q;
      tmof_d  = tmof_q;
      case (state_q)
         WAIT_W: if (wload_done_i) state_d = IDLE;
         IDLE, FEED: begin
            if (state_q == FEED && chain_end_i) endl_d = 1'b1;
            if (accept) begin
               if (s_last_i != last_pix) ferr_d = 1'b1;
               if (last_pix) begin
                  // counter, not s_last, closes the frame
                  pix_d   = '0;
                  tmo_d   = '0;
                  state_d = endl_d ? SCAN : DRAIN;
               end else begin
                  pix_d   = pix_q + PIX_W'(1);
                  state_d = FEED;
               end
            end
         end
         DRAIN: begin
            if (chain_end_i) state_d = SCAN;
            else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               state_d = RESULT;
               tmof_d  = 1'b1;
            end else tmo_d = tmo_q + TMO_W'(1);
         end
         SCAN: if (am_last) state_d = RESULT;
         RESULT: begin
            if (res_rdy_i) begin
               state_d = IDLE;
               ferr_d  = 1'b0;
               endl_d  = 1'b0;
               tmof_d  = 1'b0;
            end
         end
         default: state_d = WAIT_W;
      endcase
   end

   // per-class saturating accumulators; sum carries one guard bit for overflow detect
   for (genvar k = 0; k < CLASSES; k++) begin : g_acc
      logic signed [N-1:0]     d;
      logic signed [ACC_W:0]   sum;
      logic                    ovf;
      logic        [ACC_W-1:0] sat;
      assign d   = chain_dout_i[k*N +: N];
      assign sum = $signed({acc_q[k][ACC_W-1], acc_q[k]}) + (ACC_W+1)'(d);
      assign ovf = sum[ACC_W] != sum[ACC_W-1];
      assign sat = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      assign acc_d[k] = acc_clr ? '0 : !acc_en ? acc_q[k] : ovf ? sat : sum[ACC_W-1:0];
   end

   argmax_seq #(.CLASSES(CLASSES), .ACC_W(ACC_W)) u_argmax (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .scan_i (state_q == SCAN),
      .val_i  (acc_q[am_idx]),
      .idx_o  (am_idx),
      .last_o (am_last),
      .arg_o  (am_arg),
      .max_o  (am_max)
   );

   assign res_vld_o   = (state_q == RESULT);
   assign res_err_o   = res_vld_o & (ferr_q | tmof_q);
   assign res_class_o = (res_vld_o & ~tmof_q) ? am_arg : '0;
   assign res_score_o = (res_vld_o & ~tmof_q) ? am_max : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= WAIT_W;
         pix_q   <= '0;
         tmo_q   <= '0;
         ferr_q  <= 1'b0;
         endl_q  <= 1'b0;
         tmof_q  <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         tmo_q   <= tmo_d;
         ferr_q  <= ferr_d;
         endl_q  <= endl_d;
         tmof_q  <= tmof_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
module tb_mnist_infer_ctrl;

   localparam int C  = 10;
   localparam int FP = 784;
   localparam int T  = 4096;

   typedef logic signed [7:0] sc_t [C];
   typedef struct {
      sc_t sc;
      int  dly;
      int  hold;
      int  ecls;
      int  escore;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n, wload_done, s_vld, s_last, chain_vld_in, chain_end, res_rdy;
   logic [7:0] s_din, chain_din;
   logic [C*8-1:0] chain_dout;
   logic s_rdy, chain_vld, res_vld, res_err;
   logic [3:0] res_class;
   logic [15:0] res_score;

   // second instance: small frame, narrow accumulator for saturation
   logic s2_vld, s2_last, c2_vld, c2_end, r2_rdy;
   logic [7:0] s2_din, cd2;
   logic [C*8-1:0] c2_dout;
   logic s2_rdy, cv2, r2_vld, r2_err;
   logic [3:0] r2_cls;
   logic [7:0] r2_score;

   int total = 0, bad = 0;
   int macc[C];
   vec_t tbl[6];

   always #5 clk = ~clk;

   mnist_infer_ctrl u_dut (
      .clk_i(clk), .rst_ni(rst_n), .wload_done_i(wload_done),
      .s_vld_i(s_vld), .s_rdy_o(s_rdy), .s_din_i(s_din), .s_last_i(s_last),
      .chain_vld_o(chain_vld), .chain_din_o(chain_din),
      .chain_dout_i(chain_dout), .chain_vld_in_i(chain_vld_in), .chain_end_i(chain_end),
      .res_vld_o(res_vld), .res_rdy_i(res_rdy), .res_class_o(res_class),
      .res_score_o(res_score), .res_err_o(res_err)
   );

   mnist_infer_ctrl #(.INPUT_SIZE(2), .OUT_PIXELS(4), .ACC_W(8), .TIMEOUT(64)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .wload_done_i(wload_done),
      .s_vld_i(s2_vld), .s_rdy_o(s2_rdy), .s_din_i(s2_din), .s_last_i(s2_last),
      .chain_vld_o(cv2), .chain_din_o(cd2),
      .chain_dout_i(c2_dout), .chain_vld_in_i(c2_vld), .chain_end_i(c2_end),
      .res_vld_o(r2_vld), .res_rdy_i(r2_rdy), .res_class_o(r2_cls),
      .res_score_o(r2_score), .res_err_o(r2_err)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   function automatic logic [C*8-1:0] pack(input sc_t b);
      logic [C*8-1:0] r;
      for (int k = 0; k < C; k++) r[k*8 +: 8] = b[k];
      return r;
   endfunction

   function automatic sc_t mk(input int base, input int k1, input int v1, input int k2, input int v2);
      sc_t r;
      for (int k = 0; k < C; k++) r[k] = 8'(base);
      if (k1 >= 0) r[k1] = 8'(v1);
      if (k2 >= 0) r[k2] = 8'(v2);
      return r;
   endfunction

   function automatic sc_t rnd_sc();
      sc_t r;
      for (int k = 0; k < C; k++) r[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) r[$urandom_range(5, 9)] = r[$urandom_range(0, 4)];
      return r;
   endfunction

   // reference: each beat adds with clamping to the 16-bit signed range
   task automatic model_clear();
      for (int k = 0; k < C; k++) macc[k] = 0;
   endtask

   task automatic model_beat(input sc_t b);
      for (int k = 0; k < C; k++) begin
         int v;
         v = macc[k] + int'(b[k]);
         macc[k] = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
      end
   endtask

   function automatic int model_arg();
      int best;
      best = 0;
      for (int k = 1; k < C; k++) if (macc[k] > macc[best]) best = k;
      return best;
   endfunction

   // drives nfeed pixels; s_last on beat last_pos (1-based, 0 = never);
   // optional chain beat + chain_end alongside pixel index early_at
   task automatic feed(input int last_pos, input int nfeed, input int early_at, input sc_t b);
      int hb;
      hb = 0;
      for (int i = 0; i < nfeed; i++) begin
         s_vld = 1'b1;
         s_din = 8'($urandom);
         s_last = (i == last_pos - 1);
         if (i == early_at) begin
            chain_dout = pack(b);
            chain_vld_in = 1'b1;
            chain_end = 1'b1;
            model_beat(b);
         end
         #1;
         if (s_rdy !== 1'b1 || chain_vld !== 1'b1 || chain_din !== s_din) hb++;
         @(negedge clk);
         chain_vld_in = 1'b0;
         chain_end = 1'b0;
      end
      s_vld = 1'b0;
      s_last = 1'b0;
      chk("feed_handshake_errs", hb, 0);
   endtask

   task automatic drive_beat(input sc_t b);
      chain_dout = pack(b);
      chain_vld_in = 1'b1;
      model_beat(b);
      @(negedge clk);
      chain_vld_in = 1'b0;
   endtask

   task automatic pulse_end();
      chain_end = 1'b1;
      @(negedge clk);
      chain_end = 1'b0;
   endtask

   task automatic wait_res(input int start, input int exp_lat, input int bound);
      int lat, rdy_hi;
      lat = start;
      rdy_hi = 0;
      while (res_vld !== 1'b1 && lat < bound) begin
         if (s_rdy !== 1'b0) rdy_hi++;
         @(negedge clk);
         lat++;
      end
      chk("res_latency", lat, exp_lat);
      chk("s_rdy_while_busy", rdy_hi, 0);
   endtask

   task automatic consume(input int hold, input int ecls, input longint escore, input bit eerr);
      int unst;
      chk("res_vld", res_vld, 1);
      chk("res_class", res_class, ecls);
      chk("res_score", $signed(res_score), escore);
      chk("res_err", res_err, eerr);
      unst = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (res_vld !== 1'b1 || res_class !== 4'(ecls) || res_score !== 16'(escore) ||
             res_err !== eerr || s_rdy !== 1'b0) unst++;
      end
      chk("res_hold_unstable", unst, 0);
      res_rdy = 1'b1;
      @(negedge clk);
      res_rdy = 1'b0;
      chk("post_hs_res_vld", res_vld, 0);
      chk("post_hs_s_rdy", s_rdy, 1);
   endtask

   task automatic run_vec(input vec_t v);
      model_clear();
      feed(FP, FP, -1, v.sc);
      drive_beat(v.sc);
      repeat (v.dly) @(negedge clk);
      pulse_end();
      wait_res(1, C + 1, 60);
      consume(v.hold, v.ecls, v.escore, 1'b0);
   endtask

   task automatic sat_frame(input logic [C*8-1:0] d, input int ecls, input int escore);
      int hb, lat;
      hb = 0;
      for (int i = 0; i < 4; i++) begin
         s2_vld = 1'b1;
         s2_din = 8'($urandom);
         s2_last = (i == 3);
         #1;
         if (s2_rdy !== 1'b1 || cv2 !== 1'b1 || cd2 !== s2_din) hb++;
         @(negedge clk);
      end
      s2_vld = 1'b0;
      s2_last = 1'b0;
      chk("sat_feed_errs", hb, 0);
      c2_dout = d;
      c2_vld = 1'b1;
      repeat (4) @(negedge clk);
      c2_vld = 1'b0;
      c2_end = 1'b1;
      @(negedge clk);
      c2_end = 1'b0;
      lat = 1;
      while (r2_vld !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      chk("sat_latency", lat, C + 1);
      chk("sat_class", r2_cls, ecls);
      chk("sat_score", $signed(r2_score), escore);
      chk("sat_err", r2_err, 0);
      r2_rdy = 1'b1;
      @(negedge clk);
      r2_rdy = 1'b0;
      chk("sat_post_hs_vld", r2_vld, 0);
   endtask

   initial begin
      sc_t b;
      int wb, nb, cls;
      logic [C*8-1:0] d2;

      tbl[0] = '{mk(-5, 7, 90, -1, 0),     3, 20, 7, 90};
      tbl[1] = '{mk(10, 2, 40, 5, 40),     0,  0, 2, 40};
      tbl[2] = '{mk(-3, -1, 0, -1, 0),     1,  2, 0, -3};
      tbl[3] = '{mk(-128, 9, 127, -1, 0),  2,  0, 9, 127};
      tbl[4] = '{mk(-128, -1, 0, -1, 0),   0,  1, 0, -128};
      tbl[5] = '{mk(0, 0, 1, 4, -1),       5,  0, 0, 1};

      rst_n = 1'b0; wload_done = 1'b0; s_vld = 1'b0; s_last = 1'b0; s_din = '0;
      chain_dout = '0; chain_vld_in = 1'b0; chain_end = 1'b0; res_rdy = 1'b0;
      s2_vld = 1'b0; s2_last = 1'b0; s2_din = '0; c2_dout = '0; c2_vld = 1'b0;
      c2_end = 1'b0; r2_rdy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_rdy", s_rdy, 0);
      chk("rst_res_vld", res_vld, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_res_class", res_class, 0);
      chk("rst_res_score", res_score, 0);
      chk("rst_chain_vld", chain_vld, 0);

      // weights not loaded: input must be held off
      rst_n = 1'b1;
      s_vld = 1'b1;
      wb = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (s_rdy !== 1'b0 || chain_vld !== 1'b0) wb++;
      end
      chk("wait_w_blocked_cycles", wb, 0);
      s_vld = 1'b0;
      wload_done = 1'b1;
      @(negedge clk);
      chk("idle_after_wload", s_rdy, 1);
      wload_done = 1'b0;   // drop outside WAIT_W must not matter

      foreach (tbl[i]) run_vec(tbl[i]);

      // s_last too early: frame still ends at FP, result flagged
      model_clear();
      b = rnd_sc();
      feed(500, FP, -1, b);
      drive_beat(b);
      pulse_end();
      wait_res(1, C + 1, 60);
      cls = model_arg();
      consume(0, cls, macc[cls], 1'b1);

      // chain never ends: drain timeout
      model_clear();
      b = mk(3, 6, 50, -1, 0);
      feed(FP, FP, -1, b);
      drive_beat(b);
      wait_res(2, T + 1, T + 50);
      consume(1, 0, 0, 1'b1);

      // randomized frames against the reference model
      for (int f = 0; f < 6; f++) begin
         model_clear();
         if ($urandom_range(0, 3) == 0) begin
            b = rnd_sc();
            feed(FP, FP, $urandom_range(FP - 14, FP - 1), b);
         end else begin
            b = rnd_sc();
            feed(FP, FP, -1, b);
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) drive_beat(rnd_sc());
            repeat ($urandom_range(0, 4)) @(negedge clk);
            pulse_end();
         end
         wait_res(1, C + 1, 60);
         cls = model_arg();
         consume($urandom_range(0, 3), cls, macc[cls], 1'b0);
      end

      // reset in the middle of a frame
      wload_done = 1'b1;
      model_clear();
      feed(0, 300, 100, mk(60, -1, 0, -1, 0));
      s_vld = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_s_rdy", s_rdy, 0);
      chk("midrst_chain_vld", chain_vld, 0);
      chk("midrst_res_vld", res_vld, 0);
      chk("midrst_res_err", res_err, 0);
      chk("midrst_res_class", res_class, 0);
      chk("midrst_res_score", res_score, 0);
      @(negedge clk);
      rst_n = 1'b1;
      s_vld = 1'b0;
      #1;
      chk("postrst_wait_w", s_rdy, 0);
      @(negedge clk);
      chk("postrst_idle", s_rdy, 1);
      wload_done = 1'b0;
      run_vec(tbl[2]);

      // narrow accumulator: 4 beats must clamp
      d2 = '0;
      d2[3*8 +: 8] = 8'sd127;
      d2[0 +: 8]   = 8'h80;
      d2[1*8 +: 8] = 8'd20;
      sat_frame(d2, 3, 127);
      sat_frame({C{8'h80}}, 0, -128);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
